pipe_stage_regs: RTL

- Register bank for the five-stage Y86-64 pipeline: the F predicted-PC register and the D, E, M and W stage registers.
- Consumes the stall/bubble/set_cc decisions from the pipeline hazard-control logic.
- Each cycle it either loads, holds (stall) or injects a NOP (bubble) per stage.
- Also carries the condition-code register and retirement/cycle counters for the bench.

---
 rtl/pipe_stage_regs.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_regs.sv
// Y86-64 pipeline register bank: predicted PC, D/E/M/W stage registers,
// condition codes, and the cycle/retirement counters used by the bench.
module pipe_stage_regs #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             W_stall,
  input  logic             set_cc,
  input  logic [2:0]       e_cc,
  input  logic [63:0]      f_predPC,
  input  logic [145:0]     f_bus,
  input  logic [217:0]     d_bus,
  input  logic [142:0]     e_bus,
  input  logic [141:0]     m_bus,
  output logic [63:0]      F_predPC,
  output logic [145:0]     D_bus,
  output logic [217:0]     E_bus,
  output logic [142:0]     M_bus,
  output logic [141:0]     W_bus,
  output logic [2:0]       CC,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam logic [1:0] STAT_AOK   = 2'b00;
  localparam logic [3:0] ICODE_NOP  = 4'h1;
  localparam logic [3:0] RNONE      = 4'hF;
  localparam logic [2:0] CC_RESET   = 3'b100;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Bubble images: AOK, NOP, ifun 0, every register ID RNONE, data zeroed.
  function automatic logic [145:0] d_nop();
    return {STAT_AOK, ICODE_NOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0};
  endfunction

  function automatic logic [217:0] e_nop();
    return {STAT_AOK, ICODE_NOP, 4'h0, 64'h0, 64'h0, 64'h0,
            RNONE, RNONE, RNONE, RNONE};
  endfunction

  function automatic logic [142:0] m_nop();
    return {STAT_AOK, ICODE_NOP, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
  endfunction

  function automatic logic [141:0] w_nop();
    return {STAT_AOK, ICODE_NOP, 64'h0, 64'h0, RNONE, RNONE};
  endfunction

  logic [63:0]      pred_pc_q, pred_pc_d;
  logic [145:0]     d_reg_q,   d_reg_d;
  logic [217:0]     e_reg_q,   e_reg_d;
  logic [142:0]     m_reg_q,   m_reg_d;
  logic [141:0]     w_reg_q,   w_reg_d;
  logic [2:0]       cc_q,      cc_d;
  logic [CNT_W-1:0] cycle_q,   cycle_d;
  logic [CNT_W-1:0] instr_q,   instr_d;

  logic [1:0] w_stat;
  logic [1:0] m_in_stat;
  logic [3:0] m_in_icode;
  logic       halted;
  logic       retire;

  assign w_stat     = w_reg_q[141:140];
  assign m_in_stat  = m_bus[141:140];
  assign m_in_icode = m_bus[139:136];

  always_comb begin
    pred_pc_d = pred_pc_q;
    d_reg_d   = d_reg_q;
    e_reg_d   = e_reg_q;
    m_reg_d   = m_reg_q;
    w_reg_d   = w_reg_q;
    cc_d      = cc_q;
    cycle_d   = cycle_q;
    instr_d   = instr_q;
    halted    = (w_stat != STAT_AOK);
    retire    = 1'b0;

    if (!F_stall) pred_pc_d = f_predPC;

    // Stall outranks bubble, so a conflicting D request degenerates to a hold.
    if (!D_stall) d_reg_d = D_bubble ? d_nop() : f_bus;

    e_reg_d = E_bubble ? e_nop() : d_bus;
    m_reg_d = M_bubble ? m_nop() : e_bus;

    if (!W_stall) w_reg_d = m_bus;

    if (set_cc) cc_d = e_cc;

    // A retirement is a real, fault-free instruction entering W while running.
    retire = !W_stall && (m_in_icode != ICODE_NOP) &&
             (m_in_stat == STAT_AOK) && !halted;

    if (!halted) cycle_d = cycle_q + CNT_ONE;
    if (retire)  instr_d = instr_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_pc_q <= RESET_PC;
      d_reg_q   <= d_nop();
      e_reg_q   <= e_nop();
      m_reg_q   <= m_nop();
      w_reg_q   <= w_nop();
      cc_q      <= CC_RESET;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      pred_pc_q <= pred_pc_d;
      d_reg_q   <= d_reg_d;
      e_reg_q   <= e_reg_d;
      m_reg_q   <= m_reg_d;
      w_reg_q   <= w_reg_d;
      cc_q      <= cc_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

  assign F_predPC  = pred_pc_q;
  assign D_bus     = d_reg_q;
  assign E_bus     = e_reg_q;
  assign M_bus     = m_reg_q;
  assign W_bus     = w_reg_q;
  assign CC        = cc_q;
  assign cycle_cnt = cycle_q;
  assign instr_cnt = instr_q;

endmodule
